// File: rtl/serial_frame_ctrl.sv
// rtl/serial_frame_ctrl.sv - serial start-bit framer with optional even parity and valid/ready hold
//
// Ports:
//   Clk    - rising-edge clock
//   Rst_n  - asynchronous active-low reset
//   D      - serial input; a 1 in IDLE is a start bit, data follows LSB-first
//   Ready  - downstream accept, only looked at while a word is held
//   X      - last captured data word (WIDTH bits), changes only when a frame is captured
//   Y      - accepted-frame count, modulo 16
//   Valid  - X holds a frame not yet accepted
//   Err    - one-cycle pulse after a parity mismatch
//   Busy   - frame in progress or held (state != IDLE)
module serial_frame_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PARITY = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             D,
    input  logic             Ready,
    output logic [WIDTH-1:0] X,
    output logic [3:0]       Y,
    output logic             Valid,
    output logic             Err,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] shadow_next;
    logic             last_bit;

    // Shifting in from the top means that after WIDTH shifts the first
    // data bit has walked down to bit 0, giving LSB-first order.
    assign shadow_next = {D, shadow[WIDTH-1:1]};
    assign last_bit    = (cnt == 4'(WIDTH - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            cnt    <= 4'd0;
            X      <= '0;
            Y      <= 4'd0;
            Valid  <= 1'b0;
            Err    <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (D) begin
                        state <= SHIFT;
                        cnt   <= 4'd0;
                        Busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    shadow <= shadow_next;
                    cnt    <= cnt + 4'd1;
                    if (last_bit) begin
                        if (PARITY != 0) begin
                            state <= PAR;
                        end else begin
                            state <= HOLD;
                            X     <= shadow_next;
                            Valid <= 1'b1;
                        end
                    end
                end
                PAR: begin
                    // Even parity: the parity bit must equal the XOR of the data bits.
                    if ((^shadow) == D) begin
                        state <= HOLD;
                        X     <= shadow;
                        Valid <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        Err    <= 1'b1;
                        Busy   <= 1'b0;
                        shadow <= '0;
                    end
                end
                HOLD: begin
                    // D is ignored here, and the accept edge itself does not
                    // look for a start bit; IDLE resumes detection next edge.
                    if (Valid && Ready) begin
                        state <= IDLE;
                        Valid <= 1'b0;
                        Y     <= Y + 4'd1;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb/tb_serial_frame_ctrl.sv - directed scoreboard bench for serial_frame_ctrl (parity and no-parity instances)
module tb_serial_frame_ctrl;

    logic       Clk;
    logic       Rst_n;
    logic       D0, Ready0, Valid0, Err0, Busy0;
    logic [3:0] X0, Y0;
    logic       D1, Ready1, Valid1, Err1, Busy1;
    logic [3:0] X1, Y1;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    logic [3:0] exp_y;
    logic       err1_seen;

    serial_frame_ctrl #(.WIDTH(4), .PARITY(1)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .D(D0), .Ready(Ready0),
        .X(X0), .Y(Y0), .Valid(Valid0), .Err(Err0), .Busy(Busy0)
    );

    serial_frame_ctrl #(.WIDTH(4), .PARITY(0)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .D(D1), .Ready(Ready1),
        .X(X1), .Y(Y1), .Valid(Valid1), .Err(Err1), .Busy(Busy1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial err1_seen = 1'b0;
    always @(negedge Clk) if (Err1 === 1'b1) err1_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_body0(input logic [3:0] data, input bit good);
        if (good) exp_q0.push_back(data);
        for (int i = 0; i < 4; i++) begin
            D0 = data[i];
            tick();
        end
        D0 = good ? (^data) : ~(^data);
        tick();
        D0 = 1'b0;
    endtask

    task automatic send_frame0(input logic [3:0] data, input bit good);
        D0 = 1'b1;
        tick();
        send_body0(data, good);
    endtask

    task automatic expect_frame0(input string tag);
        logic [3:0] e;
        chk({tag, "_valid"}, 32'(Valid0), 32'd1);
        chk({tag, "_err"}, 32'(Err0), 32'd0);
        if (exp_q0.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q0.pop_front();
            chk({tag, "_x"}, 32'(X0), 32'(e));
        end
    endtask

    initial begin
        Rst_n = 1'b0; D0 = 1'b0; Ready0 = 1'b0; D1 = 1'b0; Ready1 = 1'b0;
        #2;
        chk("rst_x", 32'(X0), 32'd0);
        chk("rst_y", 32'(Y0), 32'd0);
        chk("rst_valid", 32'(Valid0), 32'd0);
        chk("rst_err", 32'(Err0), 32'd0);
        chk("rst_busy", 32'(Busy0), 32'd0);
        tick();
        tick();
        Rst_n = 1'b1;

        // Parity error straight out of reset
        send_frame0(4'h3, 1'b0);
        chk("perr_err", 32'(Err0), 32'd1);
        chk("perr_valid", 32'(Valid0), 32'd0);
        chk("perr_x", 32'(X0), 32'd0);
        chk("perr_y", 32'(Y0), 32'd0);
        chk("perr_busy", 32'(Busy0), 32'd0);
        tick();
        chk("perr_err_one_cycle", 32'(Err0), 32'd0);

        // Basic frame 1,1,0,1,1,1 with Ready high
        Ready0 = 1'b1;
        send_frame0(4'hD, 1'b1);
        expect_frame0("basic");
        chk("basic_y_before", 32'(Y0), 32'd0);
        tick();
        chk("basic_valid_drop", 32'(Valid0), 32'd0);
        chk("basic_y", 32'(Y0), 32'd1);
        chk("basic_busy", 32'(Busy0), 32'd0);
        chk("basic_x_kept", 32'(X0), 32'hD);

        // Backpressure with D toggling in HOLD
        Ready0 = 1'b0;
        send_frame0(4'h6, 1'b1);
        expect_frame0("bp");
        for (int i = 0; i < 6; i++) begin
            D0 = ~i[0];
            tick();
            chk("bp_x_stable", 32'(X0), 32'h6);
            chk("bp_valid", 32'(Valid0), 32'd1);
        end
        D0 = 1'b1;
        Ready0 = 1'b1;
        tick();
        chk("bp_accept_valid", 32'(Valid0), 32'd0);
        chk("bp_accept_y", 32'(Y0), 32'd2);
        chk("bp_no_start_on_accept", 32'(Busy0), 32'd0);
        tick();
        chk("bp_start_next_edge", 32'(Busy0), 32'd1);
        send_body0(4'h9, 1'b1);
        expect_frame0("bp_next");
        tick();
        chk("bp_next_y", 32'(Y0), 32'd3);

        // Reset after two data bits
        D0 = 1'b1; tick();
        D0 = 1'b1; tick();
        D0 = 1'b0; tick();
        chk("mid_busy", 32'(Busy0), 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_x", 32'(X0), 32'd0);
        chk("mid_rst_y", 32'(Y0), 32'd0);
        chk("mid_rst_valid", 32'(Valid0), 32'd0);
        chk("mid_rst_err", 32'(Err0), 32'd0);
        chk("mid_rst_busy", 32'(Busy0), 32'd0);
        tick();
        Rst_n = 1'b1;
        send_frame0(4'hA, 1'b1);
        expect_frame0("post_rst");
        tick();
        chk("post_rst_y", 32'(Y0), 32'd1);

        // Counter wrap across 17 frames
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        exp_y = 4'd0;
        for (int i = 0; i < 17; i++) begin
            send_frame0(4'(i * 7 + 3), 1'b1);
            expect_frame0("wrap");
            tick();
            exp_y = exp_y + 4'd1;
            chk("wrap_y", 32'(Y0), 32'(exp_y));
        end

        // No-parity instance: 1,0,0,0,1 -> 4'h8
        Ready1 = 1'b1;
        exp_q1.push_back(4'h8);
        D1 = 1'b1; tick();
        D1 = 1'b0; tick();
        tick();
        tick();
        chk("np_valid_early", 32'(Valid1), 32'd0);
        D1 = 1'b1; tick();
        D1 = 1'b0;
        chk("np_valid", 32'(Valid1), 32'd1);
        chk("np_x", 32'(X1), 32'(exp_q1.pop_front()));
        chk("np_busy", 32'(Busy1), 32'd1);
        tick();
        chk("np_accept_valid", 32'(Valid1), 32'd0);
        chk("np_y", 32'(Y1), 32'd1);
        chk("np_err_never", 32'(err1_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
